// File: rtl/sys_types_pkg.sv
// sys_types: shared integer types and zero-point encodings for requantizer and dequantizer
package sys_types;
    typedef logic signed [7:0]  int8_t;
    typedef logic signed [15:0] int16_t;
    localparam int NORM_ZERO_POINT    = -128;
    localparam int SPECIAL_ZERO_POINT = -1;
    localparam int LANES_PER_WORD     = 4;
    typedef enum logic {IDLE, UNPACK} unpack_state_e;
endpackage

// File: rtl/dequant_unpack_unit_zp_subtract.sv
// zp_subtract: int8 minus zero point in 9-bit signed, sign-extended to int16
module zp_subtract
    import sys_types::*;
(
    input  int8_t  x_i,
    input  int8_t  zp_i,
    output int16_t y_o
);
    logic signed [8:0] diff;
    // 9 bits covers every int8 minus int8 result without overflow
    always_comb begin
        diff = {x_i[7], x_i} - {zp_i[7], zp_i};
        y_o  = {{7{diff[8]}}, diff};
    end
endmodule

// File: rtl/dequant_unpack_unit.sv
// dequant_unpack_unit: unpacks int8 lanes, removes zero point, streams one int16 lane per beat
module dequant_unpack_unit
    import sys_types::*;
#(
    parameter int LANES      = LANES_PER_WORD,
    parameter int NORM_ZP    = NORM_ZERO_POINT,
    parameter int SPECIAL_ZP = SPECIAL_ZERO_POINT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*LANES-1:0]       in_data,
    input  logic [$clog2(LANES):0]   in_nlanes,
    input  logic                     in_last,
    input  logic                     in_choose_zp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [$clog2(LANES)-1:0] out_lane,
    output logic                     out_last
);
    localparam int LW = $clog2(LANES);
    localparam int NW = LW + 1;

    unpack_state_e      state_q, state_d;
    logic [LW-1:0]      lc_q, lc_d;
    logic [NW-1:0]      nl_q, nl_in;
    logic [8*LANES-1:0] word_q;
    logic               last_q;
    int8_t              zp_q;
    int16_t             diff;
    logic               last_lane, accept, xfer;

    assign nl_in     = (in_nlanes == '0 || in_nlanes > NW'(LANES)) ? NW'(LANES) : in_nlanes;
    assign last_lane = {1'b0, lc_q} == nl_q - NW'(1);
    assign in_ready  = state_q == IDLE || (out_ready && last_lane);
    assign out_valid = state_q == UNPACK;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    zp_subtract u_sub (
        .x_i (word_q[8*lc_q +: 8]),
        .zp_i(zp_q),
        .y_o (diff)
    );

    // Outputs read only held registers, so backpressure keeps them stable
    always_comb begin
        out_data = out_valid ? diff : '0;
        out_lane = out_valid ? lc_q : '0;
        out_last = out_valid && last_q && last_lane;
    end

    // Next state: advance lane on transfer, retire word on last lane, new word overrides
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        if (xfer) begin
            lc_d    = last_lane ? lc_q : lc_q + LW'(1);
            state_d = last_lane ? IDLE : state_q;
        end
        if (accept) begin
            state_d = UNPACK;
            lc_d    = '0;
        end
    end

    // State, lane counter and word capture; word fields are sampled only at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lc_q    <= '0;
            nl_q    <= NW'(LANES);
            word_q  <= '0;
            last_q  <= 1'b0;
            zp_q    <= '0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            if (accept) begin
                word_q <= in_data;
                nl_q   <= nl_in;
                last_q <= in_last;
                zp_q   <= in_choose_zp ? int8_t'(SPECIAL_ZP) : int8_t'(NORM_ZP);
            end
        end
    end
endmodule

// File: tb/tb_dequant_unpack_unit.sv
// tb_dequant_unpack_unit: randomized and directed checks against a lane-queue reference model
module tb_dequant_unpack_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_last, in_choose_zp;
    logic [31:0] in_data;
    logic [2:0]  in_nlanes;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic [1:0]  out_lane;

    typedef struct {int d; int l; int last;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    dequant_unpack_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_nlanes(in_nlanes), .in_last(in_last), .in_choose_zp(in_choose_zp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare outputs with the model, update the model as the edge will
    task automatic cyc(input bit v, input logic [31:0] d, input logic [2:0] nl,
                       input bit last, input bit zs, input bit ordy);
        bit exp_ready;
        int n, zp;
        @(negedge clk);
        in_valid = v; in_data = d; in_nlanes = nl; in_last = last;
        in_choose_zp = zs; out_ready = ordy;
        #1;
        exp_ready = q.size() == 0 || (ordy && q.size() == 1);
        check("in_ready", int'(in_ready), int'(exp_ready));
        check("out_valid", int'(out_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", int'($signed(out_data)), q[0].d);
            check("out_lane", int'(out_lane), q[0].l);
            check("out_last", int'(out_last), q[0].last);
            if (ordy) void'(q.pop_front());
        end
        if (v && exp_ready) begin
            n  = nl == 0 ? 4 : int'(nl);
            zp = zs ? -1 : -128;
            for (int i = 0; i < n; i++)
                q.push_back('{int'($signed(d[8*i +: 8])) - zp, i, int'(last && i == n - 1)});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_lane", int'(out_lane), 0);
        check("rst_out_last", int'(out_last), 0);
    endtask

    task automatic idle(input int k, input bit ordy);
        for (int i = 0; i < k; i++) cyc(0, 32'h0, 3'd4, 0, 0, ordy);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_nlanes = '0;
        in_last = 1'b0; in_choose_zp = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        cyc(1, 32'h7F80_01FF, 3'd4, 1, 0, 1);
        idle(5, 1);
        cyc(1, 32'h7F80_01FF, 3'd4, 1, 1, 1);
        idle(5, 1);
        for (int i = 0; i < 9; i++) cyc(1, 32'h1122_3344 + 32'(i), 3'd4, i[0], 0, 1);
        idle(5, 1);
        cyc(1, 32'hA5C3_0F80, 3'd4, 1, 0, 1);
        cyc(1, 32'h0, 3'd4, 0, 0, 1);
        cyc(1, 32'h0, 3'd4, 0, 0, 0);
        cyc(1, 32'h0, 3'd4, 0, 0, 0);
        idle(5, 1);
        cyc(1, 32'h0000_8080, 3'd2, 1, 0, 1);
        idle(3, 1);
        for (int i = 0; i < 6; i++) cyc(1, 32'h0000_007F + 32'(i), 3'd1, 1, i[0], 1);
        idle(2, 1);
        cyc(1, 32'hDEAD_BEEF, 3'd4, 1, 0, 1);
        cyc(0, 32'h0, 3'd4, 0, 0, 1);
        do_reset();
        cyc(1, 32'h0403_0201, 3'd0, 1, 1, 1);
        idle(5, 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 1), $urandom, 3'($urandom_range(0, 4)),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) < 7);
        for (int i = 0; i < 8 && q.size() != 0; i++) cyc(0, 32'h0, 3'd4, 0, 0, 1);
        check("drain_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
